// File: rtl/accum_32bit.sv
// Streaming accumulator around an external combinational 32-bit adder.
// Sums in_last-delimited packets and holds one result word behind a valid/ready handshake.
module accum_32bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // Handshake: a word moves on a rising edge where in_valid && in_ready;
    // a result moves where out_valid && out_ready. Neither ready depends on its valid.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             ovf_sticky;
    logic             wrap;
    logic             accept;

    assign add_a     = acc;
    assign add_b     = in_data;
    assign accept    = in_valid && (state == ACCUM);
    // A modulo-2^32 sum smaller than the old accumulator means the add wrapped.
    assign wrap      = (add_sum < acc);
    assign count_inc = (&count) ? count : count + CNT_W'(1);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (in_last) begin
                    out_data   <= add_sum;
                    out_count  <= count_inc;
                    out_ovf    <= ovf_sticky | wrap;
                    acc        <= '0;
                    count      <= '0;
                    ovf_sticky <= 1'b0;
                end else begin
                    acc        <= add_sum;
                    count      <= count_inc;
                    ovf_sticky <= ovf_sticky | wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_32bit.sv
// Directed bench for accum_32bit with an ideal adder model and a result scoreboard.
module tb_accum_32bit;

    localparam int CNT_W = 4;
    localparam int W     = 32 + CNT_W + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    accum_32bit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    // External adder as the block sees it in the system.
    assign add_sum = add_a + add_b;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [CNT_W-1:0] c, input logic o);
        exp_q.push_back({d, c, o});
    endtask

    // Drivers: inputs change on the falling edge only.
    task automatic send(input logic [31:0] d, input logic last);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            if (in_ready) begin
                @(posedge clk);
                done = 1;
            end
        end
        #1;
        in_valid = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: word 0x%08h not accepted in 100 cycles", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'b1;
        end
    endtask

    // Monitor: pops one expected result per completed output handshake.
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && out_ready) begin
                n_tests++;
                a = {out_data, out_count, out_ovf};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got data=0x%08h count=%0d ovf=%0b with empty queue",
                             out_data, out_count, out_ovf);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL result: got data=0x%08h count=%0d ovf=%0b expected data=0x%08h count=%0d ovf=%0b",
                                 out_data, out_count, out_ovf, e[W-1 -: 32], e[CNT_W:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_out_count", {28'd0, out_count}, 32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf}, 32'd0);
        chk("rst_add_a",     add_a, 32'd0);

        // Packet 1,2,3
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        chk("mid_add_a", add_a, 32'd3);
        chk("mid_add_b", add_b, in_data);
        push_exp(32'd6, 4'd3, 1'b0);
        send(32'd3, 1'b1);
        @(negedge clk);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_in_ready",  {31'd0, in_ready},  32'd0);
        @(negedge clk);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_in_ready",  {31'd0, in_ready},  32'd1);
        chk("post_out_data",  out_data, 32'd6);

        // Wrap sets ovf; next packet clears it
        send(32'hFFFF_FFFF, 1'b0);
        push_exp(32'h0000_0001, 4'd2, 1'b1);
        send(32'h0000_0002, 1'b1);
        push_exp(32'd5, 4'd1, 1'b0);
        send(32'd5, 1'b1);
        idle(2);

        // Backpressure
        @(negedge clk);
        out_ready = 1'b0;
        push_exp(32'd7, 4'd1, 1'b0);
        send(32'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data",  out_data, 32'd7);
            chk("bp_in_ready",  {31'd0, in_ready}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        push_exp(32'd9, 4'd1, 1'b0);
        send(32'd9, 1'b1);
        idle(2);

        // Count saturation
        for (int i = 1; i <= 20; i++) begin
            if (i == 20) push_exp(32'd20, 4'd15, 1'b0);
            send(32'd1, (i == 20));
        end
        idle(2);

        // Gaps, with in_last high while in_valid is low
        send(32'd10, 1'b0);
        idle(2);
        send(32'd20, 1'b0);
        idle(1);
        push_exp(32'd60, 4'd3, 1'b0);
        send(32'd30, 1'b1);
        idle(2);

        // Reset mid-packet
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_add_a", add_a, 32'd0);
        push_exp(32'd4, 4'd1, 1'b0);
        send(32'd4, 1'b1);
        idle(2);

        // Reset during HOLD discards the held result
        out_ready = 1'b0;
        send(32'd8, 1'b1);
        @(negedge clk);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_out_data",  out_data, 32'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("holdrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("holdrst_out_data",  out_data, 32'd0);
        chk("holdrst_in_ready",  {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        idle(3);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_32bit.md
Name: accum_32bit

Overview:
- Sequential streaming accumulator wrapped around the team's combinational 32-bit adder.
- Sits directly around the adder:
  - Upstream: drives the adder's two operand buses.
  - Downstream: consumes the adder's sum.
- Sums a packet of 32-bit words delimited by in_last, then presents one result word with element count and unsigned-overflow flag over a valid/ready handshake.
- Adder is instantiated outside this block; the combinational round trip add_a/add_b -> add_sum is within one cycle.

Parameters:
- CNT_W, 8, width of element counter; count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept an input word.
- in_data  input  32  operand word.
- in_last  input  1  qualifies final word of packet; sampled with in_valid.
- add_a  output  32  adder operand a = accumulator register.
- add_b  output  32  adder operand b = in_data, passed through combinationally.
- add_sum  input  32  adder result (a+b mod 2^32, no carry-out).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  32  packet sum mod 2^32.
- out_count  output  CNT_W  number of words in packet, saturating.
- out_ovf  output  1  sticky: at least one unsigned wrap occurred in packet.

Behaviour:
- Reset (rst=1 at clock edge):
  - acc, count, ovf_sticky cleared to 0.
  - State = ACCUM.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - rst overrides every other input in the same cycle; asserting it mid-packet or while a result is held discards all state.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready.
- ACCUM, accept with in_last=0:
  - acc <= add_sum.
  - count <= count+1; stays at all-ones if already saturated.
  - ovf_sticky <= ovf_sticky | (add_sum < acc), unsigned compare.
  - Remain in ACCUM.
- ACCUM, accept with in_last=1:
  - out_data <= add_sum.
  - out_count <= count+1 (saturating).
  - out_ovf <= ovf_sticky | (add_sum < acc).
  - acc, count, ovf_sticky <= 0.
  - Go to HOLD.
- Latency: result visible (out_valid=1) the cycle after the last word is accepted.
- ACCUM, no accept: all state held.
- HOLD:
  - out_data/out_count/out_ovf stable while out_valid=1 && out_ready=0.
  - On out_ready=1, go to ACCUM next cycle; out_* retain their values but out_valid=0.
  - Input words arriving during HOLD are not accepted (in_ready=0); the producer holds them.
- No bubble requirement: one cycle of in_ready=0 after result consumption is not required; in_ready rises in the same cycle out_valid falls.
- Single-word packet (in_last on first word): out_data = in_data (acc=0), out_count=1, out_ovf=0.
- add_a always equals the acc register; add_b always equals in_data, whether or not a word is accepted.
- in_last with in_valid=0 is ignored.
- Width rules:
  - Sum is modulo 2^32.
  - Overflow is detected only via the unsigned compare above; no carry-out from the adder is used.

Test Plan:
- Reset then packet 1,2,3 (last on 3), out_ready=1 -> out_valid one cycle after last; out_data=6, out_count=3, out_ovf=0; in_ready=0 only during HOLD cycle.
- Packet 0xFFFFFFFF, 0x00000002 (last) -> out_data=0x00000001, out_ovf=1; next packet 5 (last) -> out_data=5, out_ovf=0 (sticky cleared).
- Backpressure: packet 7 (last), out_ready=0 for 5 cycles -> out_valid/out_data=7 stable, in_ready=0, in_valid held high with 9 not accepted; after out_ready=1, 9 (last) yields out_data=9, out_count=1.
- Count saturation with CNT_W=4: 20 words of value 1, last on 20th -> out_data=20, out_count=15.
- Gaps: in_valid toggled 1,0,0,1,0,1 with data 10,x,x,20,x,30(last) -> out_data=60, out_count=3.
- Reset mid-packet: accept 100,200, assert rst one cycle, then packet 4 (last) -> out_data=4, out_count=1; rst during HOLD -> out_valid=0 next cycle.
